// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock through a half-adder-pair full adder, valid/ready on both sides.
// Optional abort input is enabled by defining SERIAL_ADDER_ABORT_EN.

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef SERIAL_ADDER_ABORT_EN
   input  logic             abort,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra, rb;
   logic [WIDTH-2:0] acc;
   logic             carry;
   logic             s1, c1, c2, fa_s, fa_c;
   logic [WIDTH-1:0] sum_nxt;
   logic             accept, last, abort_i;

`ifdef SERIAL_ADDER_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   half_adder u_ha0 (.x(ra[0]), .y(rb[0]), .s(s1),   .c(c1));
   half_adder u_ha1 (.x(s1),    .y(carry), .s(fa_s), .c(c2));
   assign fa_c = c1 | c2;

   // New bit enters at the MSB; after WIDTH shifts the word is in place.
   assign sum_nxt = {fa_s, acc};
   assign accept  = (state == IDLE) && in_valid && in_ready;
   assign last    = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN: begin
            if (abort_i)   state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: if (abort_i || out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == DONE);
   end

   // Registered so it stays low through reset and rises on the first edge after release.
   always_ff @(posedge clk) begin
      if (!rst_n) in_ready <= 1'b0;
      else        in_ready <= (state_nxt == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
      end else if (state == RUN) begin
         if (abort_i) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            if (last) begin
               sum      <= sum_nxt;
               c_out    <= fa_c;
               overflow <= carry ^ fa_c;
               zero     <= (sum_nxt == '0);
               negative <= fa_s;
            end
         end
      end else if (accept) begin
         cnt <= '0;
      end
   end

   // Operand/carry shift registers carry no reset; the control path qualifies them.
   always_ff @(posedge clk) begin
      if (accept) begin
         ra    <= a;
         rb    <= sub ? ~b : b;
         carry <= sub;
      end else if (state == RUN) begin
         ra    <= ra >> 1;
         rb    <= rb >> 1;
         acc   <= sum_nxt[WIDTH-1:1];
         carry <= fa_c;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8: directed and random operations against an arithmetic reference model.
module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         c_out, overflow, zero, negative;
`ifdef SERIAL_ADDER_ABORT_EN
   logic         abort = 1'b0;
`endif

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] last_sum = '0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub),
`ifdef SERIAL_ADDER_ABORT_EN
      .abort(abort),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .overflow(overflow), .zero(zero), .negative(negative)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain integer arithmetic; carry for subtraction means "no borrow".
   function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic ms,
                                 output logic [7:0] es, output logic ec, output logic eov,
                                 output logic ez, output logic en);
      int ua, ub, sa, sb, r, res;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (ms) begin
         r   = ua - ub;
         ec  = (ua >= ub);
         res = sa - sb;
      end else begin
         r   = ua + ub;
         ec  = (r > 255);
         res = sa + sb;
      end
      es  = 8'(r);
      eov = (res > 127) || (res < -128);
      ez  = (es == 8'd0);
      en  = es[7];
   endfunction

   task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts);
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_before_op", int'(in_ready), 1);
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts, input bit churn);
      logic [7:0] es;
      logic       ec, eov, ez, en;
      int         lat = 0;
      bit         done = 0;
      model(ta, tb_v, ts, es, ec, eov, ez, en);
      start_op(ta, tb_v, ts);
      while (!done && lat < 40) begin
         if (churn) begin
            a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
         if (lat == 4) check("sum_hold_during_run", int'(sum), int'(last_sum));
         if (out_valid === 1'b1) done = 1;
      end
      in_valid = 1'b0;
      check("latency", lat, W);
      check("sum", int'(sum), int'(es));
      check("c_out", int'(c_out), int'(ec));
      check("overflow", int'(overflow), int'(eov));
      check("zero", int'(zero), int'(ez));
      check("negative", int'(negative), int'(en));
      check("in_ready_done", int'(in_ready), 0);
      last_sum = es;
      if (out_ready) begin
         tick();
         check("out_valid_after_hs", int'(out_valid), 0);
         check("in_ready_after_hs", int'(in_ready), 1);
      end
   endtask

   initial begin
      logic [7:0] held;
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] held;
      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_sum", int'(sum), 0);
      check("rst_flags", int'({c_out, overflow, zero, negative}), 0);
      rst_n = 1'b1;
      tick();
      check("in_ready_after_rst", int'(in_ready), 1);

      // Directed boundary cases
      run_op(8'h7F, 8'h01, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 0);
      run_op(8'h05, 8'h05, 1'b1, 0);
      run_op(8'h03, 8'h05, 1'b1, 0);
      run_op(8'h80, 8'h01, 1'b1, 0);
      run_op(8'h00, 8'h00, 1'b0, 0);

      // Random operations, half of them with operand churn during RUN
      for (int i = 0; i < 24; i++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), (i % 2) == 1);

      // Backpressure
      out_ready = 1'b0;
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1);
      held = sum;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         tick();
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_sum", int'(sum), int'(held));
         check("bp_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_out_valid", int'(out_valid), 0);
      check("bp_release_in_ready", int'(in_ready), 1);

      // Reset in the middle of RUN at counter 3
      start_op(8'h11, 8'h22, 1'b0);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_sum", int'(sum), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      last_sum = '0;
      tick();
      check("midrst_in_ready_after", int'(in_ready), 1);
      run_op(8'hA5, 8'h3C, 1'b1, 0);

`ifdef SERIAL_ADDER_ABORT_EN
      run_op(8'h12, 8'h34, 1'b0, 0);
      start_op(8'h55, 8'h66, 1'b1);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_sum_kept", int'(sum), int'(last_sum));
      for (int i = 0; i < 10; i++) begin
         check("abort_no_valid", int'(out_valid), 0);
         tick();
      end
      run_op(8'h40, 8'h40, 1'b0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder/subtractor in the ALU adders group. It accepts two WIDTH-bit operands over a valid/ready handshake, then processes one bit per cycle through an internal full adder. The full adder is two halfAdder instances plus an OR for carry. Results and ALU flags (carry, overflow, zero, negative) go downstream over a second valid/ready handshake. It is the area-minimal alternative feeding the same flag consumers as the parallel adder.

Parameters:
WIDTH, 64, operand/result width in bits (legal: >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operands a, b, sub valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  1 = A - B, 0 = A + B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B or A-B, modulo 2^WIDTH
c_out  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow
zero  output  1  sum == 0
negative  output  1  sum[WIDTH-1]

Behaviour:
- Reset is synchronous, active-low, sampled on the clk edge. While rst_n=0 the block enters IDLE. Reset values: in_ready=0 while rst_n=0, then 1 from the first edge after deassertion; out_valid=0; sum=0, c_out=0, overflow=0, zero=0, negative=0; bit counter=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, operands are accepted. Load A into shift register ra and (sub ? ~b : b) into rb. Carry register = sub. Counter = 0. Go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each edge: bit s = ra[0]^rb[0]^carry; carry <= majority(ra[0], rb[0], carry).
  - s is shifted into the sum register at the MSB with a right shift. ra and rb shift right by 1. Counter increments.
  - On the edge processing bit WIDTH-1, record the carry-in to the MSB for overflow.
  - After exactly WIDTH RUN cycles, go to DONE.
- State DONE:
  - out_valid=1; sum, c_out, overflow, zero and negative are stable.
  - c_out = final carry. overflow = MSB carry-in XOR MSB carry-out. zero = (sum==0). negative = sum[WIDTH-1].
  - Outputs hold indefinitely while out_ready=0.
  - On an edge with out_valid & out_ready, go to IDLE. out_valid drops next cycle; sum and flags retain their values until the next op completes.
- Latency: operands accepted on edge t; out_valid high from edge t+WIDTH. Throughput is one op per WIDTH+2 cycles minimum (accept, WIDTH run cycles, handshake). There is no accept in DONE.
- Changes on a, b, sub and in_valid during RUN or DONE are ignored.
- A reset asserted at any state returns to IDLE with reset values on the next edge. Any partial result is discarded.
- The internal full adder uses two halfAdder instances, so per-bit combinational delay is non-zero. The design must meet clk period with ample margin; no combinational path exists from input ports to outputs.

Optional Feature:
- Macro: SERIAL_ADDER_ABORT_EN.
- Defined:
  - Adds port abort (input, 1).
  - abort=1 on an edge in RUN or DONE returns to IDLE. out_valid is forced 0 from that edge; sum and flags keep their previous completed values.
  - abort in IDLE has no effect; a simultaneous in_valid in IDLE is accepted normally.
  - If abort and out_ready coincide in DONE, abort wins; the handshake is not considered complete.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- WIDTH=8, a=0x7F, b=0x01, sub=0, out_ready=1 -> out_valid exactly 8 edges after accept; sum=0x80, c_out=0, overflow=1, negative=1, zero=0.
- WIDTH=8, a=0xFF, b=0x01, sub=0 -> sum=0x00, c_out=1, overflow=0, zero=1, negative=0. Then a=0x05, b=0x05, sub=1 -> sum=0x00, c_out=1, zero=1.
- WIDTH=8, a=0x03, b=0x05, sub=1 -> sum=0xFE, c_out=0, negative=1, overflow=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and sum held constant, in_ready=0. Assert out_ready -> next cycle out_valid=0, in_ready=1.
- Operand churn: change a, b and sub every cycle during RUN -> result matches operands sampled at accept.
- Reset: drive rst_n=0 for one edge at RUN counter=3 -> next cycle in IDLE, out_valid=0, sum=0. A new op then completes correctly. With SERIAL_ADDER_ABORT_EN, abort at counter=3 -> IDLE, no out_valid pulse, prior sum retained.
